// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative shift-add
// multiplier with front-end stall, and the EX/MEM pipeline register.
// Optional feature macro: EX_OVERFLOW_TRAP_EN (signed ADD/SUB overflow trap).
module ex_stage #(
  parameter int unsigned MUL_BITS = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] RD1E,
  input  logic [31:0] RD2E,
  input  logic [31:0] SignImmE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RtE,
  input  logic [4:0]  RdE,
  input  logic [4:0]  SaE,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MemWriteE,
  input  logic        ALUSrcE,
  input  logic        RegDstE,
  input  logic        JumpLinkE,
  input  logic [3:0]  ALUControlE,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ResultW,
  output logic        StallE,
  output logic [31:0] ALUOutM,
  output logic [31:0] WriteDataM,
  output logic [4:0]  WriteRegM,
  output logic        RegWriteM,
  output logic        MemtoRegM,
  output logic        MemWriteM,
  output logic        OverflowM
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned STEPS = XLEN / MUL_BITS;
  localparam int unsigned CNT_W = 6;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_NOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SRA = 4'b1001;
  localparam logic [3:0] ALU_MUL = 4'b1010;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} mulStateT;

  mulStateT           state, stateNext;
  logic [XLEN-1:0]    srcA, fwdB, srcB;
  logic [XLEN-1:0]    addRes, subRes, aluRes, resultE;
  logic [4:0]         writeRegE;
  logic [XLEN-1:0]    mcand, mplier, acc, partial;
  logic [CNT_W-1:0]   stepCnt;
  logic               isMul, mulStart, stallC, ovfTrap;

  // Forwarding muxes for both operands and the immediate select for B
  always_comb begin
    case (ForwardAE)
      2'b01:   srcA = ResultW;
      2'b10:   srcA = ALUOutM;
      default: srcA = RD1E;
    endcase
    case (ForwardBE)
      2'b01:   fwdB = ResultW;
      2'b10:   fwdB = ALUOutM;
      default: fwdB = RD2E;
    endcase
    srcB = ALUSrcE ? SignImmE : fwdB;
  end

  assign isMul   = (ALUControlE == ALU_MUL);
  assign addRes  = srcA + srcB;
  assign subRes  = srcA - srcB;
  assign partial = mcand * XLEN'(mplier[MUL_BITS-1:0]);

  // Single-cycle ALU; MUL reads the accumulator, which holds the product in DONE
  always_comb begin
    aluRes = '0;
    case (ALUControlE)
      ALU_AND: aluRes = srcA & srcB;
      ALU_OR:  aluRes = srcA | srcB;
      ALU_ADD: aluRes = addRes;
      ALU_XOR: aluRes = srcA ^ srcB;
      ALU_NOR: aluRes = ~(srcA | srcB);
      ALU_SLL: aluRes = srcB << SaE;
      ALU_SUB: aluRes = subRes;
      ALU_SLT: aluRes = {{(XLEN-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      ALU_SRL: aluRes = srcB >> SaE;
      ALU_SRA: aluRes = $unsigned($signed(srcB) >>> SaE);
      ALU_MUL: aluRes = acc;
      default: aluRes = '0;
    endcase
    resultE   = JumpLinkE ? PCPlus4E : aluRes;
    writeRegE = JumpLinkE ? 5'd31 : (RegDstE ? RdE : RtE);
  end

`ifdef EX_OVERFLOW_TRAP_EN
  // Signed overflow detection for ADD/SUB; suppresses the register write
  always_comb begin
    ovfTrap = 1'b0;
    case (ALUControlE)
      ALU_ADD: ovfTrap = (srcA[31] == srcB[31]) && (addRes[31] != srcA[31]);
      ALU_SUB: ovfTrap = (srcA[31] != srcB[31]) && (subRes[31] != srcA[31]);
      default: ovfTrap = 1'b0;
    endcase
  end
`else
  assign ovfTrap = 1'b0;
`endif

  // Multiplier FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= stateNext;
  end

  // Multiplier FSM next state and stall generation
  always_comb begin
    stateNext = state;
    mulStart  = 1'b0;
    stallC    = 1'b0;
    case (state)
      IDLE: begin
        if (isMul) begin
          mulStart  = 1'b1;
          stallC    = 1'b1;
          stateNext = BUSY;
        end
      end
      BUSY: begin
        stallC = 1'b1;
        if (stepCnt == CNT_W'(STEPS - 1)) stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Stall drops as soon as reset is asserted, even with a MUL still in ID/EX
  assign StallE = RST_N & stallC;

  // Shift-add datapath: operands latched at start, MUL_BITS retired per step
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      stepCnt <= '0;
    end else if (mulStart) begin
      mcand   <= srcA;
      mplier  <= srcB;
      acc     <= '0;
      stepCnt <= '0;
    end else if (state == BUSY) begin
      acc     <= acc + partial;
      mcand   <= mcand << MUL_BITS;
      mplier  <= mplier >> MUL_BITS;
      stepCnt <= stepCnt + CNT_W'(1);
    end
  end

  // EX/MEM pipeline register; a stall loads a bubble into the control bits
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ALUOutM    <= '0;
      WriteDataM <= '0;
      WriteRegM  <= '0;
      RegWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      MemWriteM  <= 1'b0;
      OverflowM  <= 1'b0;
    end else begin
      ALUOutM    <= resultE;
      WriteDataM <= fwdB;
      WriteRegM  <= writeRegE;
      if (stallC) begin
        RegWriteM <= 1'b0;
        MemtoRegM <= 1'b0;
        MemWriteM <= 1'b0;
        OverflowM <= 1'b0;
      end else begin
        RegWriteM <= RegWriteE & ~ovfTrap;
        MemtoRegM <= MemtoRegE;
        MemWriteM <= MemWriteE;
        OverflowM <= ovfTrap;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage (default MUL_BITS = 1).
module tb_ex_stage;

  logic        CLK, RST_N;
  logic [31:0] RD1E, RD2E, SignImmE, PCPlus4E, ResultW;
  logic [4:0]  RtE, RdE, SaE;
  logic        RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, JumpLinkE;
  logic [3:0]  ALUControlE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallE;
  logic [31:0] ALUOutM, WriteDataM;
  logic [4:0]  WriteRegM;
  logic        RegWriteM, MemtoRegM, MemWriteM, OverflowM;

  int nVec  = 0;
  int nMiss = 0;

  typedef struct packed {
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sa;
    logic [31:0] exp;
  } aluVecT;

  ex_stage dut (
    .CLK(CLK), .RST_N(RST_N),
    .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE), .PCPlus4E(PCPlus4E),
    .RtE(RtE), .RdE(RdE), .SaE(SaE),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .JumpLinkE(JumpLinkE),
    .ALUControlE(ALUControlE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW), .StallE(StallE),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .OverflowM(OverflowM)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    RD1E = '0; RD2E = '0; SignImmE = '0; PCPlus4E = '0; ResultW = '0;
    RtE = '0; RdE = '0; SaE = '0;
    RegWriteE = 0; MemtoRegE = 0; MemWriteE = 0; ALUSrcE = 0; RegDstE = 0; JumpLinkE = 0;
    ALUControlE = 4'b0000; ForwardAE = 2'b00; ForwardBE = 2'b00;
  endtask

  // Steps until StallE drops, bounded; returns the number of stalled cycles
  task automatic wait_stall_low(output int cycles);
    cycles = 0;
    while (StallE === 1'b1 && cycles < 200) begin
      step();
      cycles++;
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    clear_inputs();
    repeat (2) @(posedge CLK);
    #1;
    nVec++; if (ALUOutM !== 32'd0)    begin nMiss++; $display("FAIL rst_aluout got %h want 0", ALUOutM); end
    nVec++; if (WriteDataM !== 32'd0) begin nMiss++; $display("FAIL rst_wdata got %h want 0", WriteDataM); end
    nVec++; if (WriteRegM !== 5'd0)   begin nMiss++; $display("FAIL rst_wreg got %h want 0", WriteRegM); end
    nVec++; if ({RegWriteM, MemtoRegM, MemWriteM, OverflowM} !== 4'b0000)
      begin nMiss++; $display("FAIL rst_ctrl got %b want 0000", {RegWriteM, MemtoRegM, MemWriteM, OverflowM}); end
    nVec++; if (StallE !== 1'b0)      begin nMiss++; $display("FAIL rst_stall got %b want 0", StallE); end
    @(negedge CLK);
    RST_N = 1'b1;
    step();
  endtask

  task automatic test_add_imm();
    clear_inputs();
    ALUControlE = 4'b0010; RD1E = 32'd5; SignImmE = 32'd7; ALUSrcE = 1;
    RegDstE = 0; RtE = 5'd9; RdE = 5'd3; RegWriteE = 1;
    step();
    nVec++; if (ALUOutM !== 32'd12)  begin nMiss++; $display("FAIL t1_aluout got %0d want 12", ALUOutM); end
    nVec++; if (WriteRegM !== 5'd9)  begin nMiss++; $display("FAIL t1_wreg got %0d want 9", WriteRegM); end
    nVec++; if (RegWriteM !== 1'b1)  begin nMiss++; $display("FAIL t1_regwrite got %b want 1", RegWriteM); end
  endtask

  task automatic test_forwarding();
    clear_inputs();
    ALUControlE = 4'b0010; RD1E = 32'd100; ALUSrcE = 1; SignImmE = 32'd0; RegWriteE = 1;
    step();
    nVec++; if (ALUOutM !== 32'd100) begin nMiss++; $display("FAIL t2_seed got %0d want 100", ALUOutM); end
    ALUControlE = 4'b0110; ForwardAE = 2'b10; RD1E = 32'd7; RD2E = 32'd1; ALUSrcE = 0;
    step();
    nVec++; if (ALUOutM !== 32'd99)  begin nMiss++; $display("FAIL t2_fwd_mem got %0d want 99", ALUOutM); end
    ForwardAE = 2'b01; ResultW = 32'd50;
    step();
    nVec++; if (ALUOutM !== 32'd49)  begin nMiss++; $display("FAIL t2_fwd_wb got %0d want 49", ALUOutM); end
    ALUControlE = 4'b0010; ForwardAE = 2'b00; ForwardBE = 2'b10; RD1E = 32'd1;
    step();
    nVec++; if (ALUOutM !== 32'd50)  begin nMiss++; $display("FAIL t2_fwd_b got %0d want 50", ALUOutM); end
    ForwardAE = 2'b11; RD1E = 32'h20; ResultW = 32'hDEAD; ALUSrcE = 1; SignImmE = 32'd1;
    step();
    nVec++; if (ALUOutM !== 32'h21)  begin nMiss++; $display("FAIL t2_fwd_11 got %h want 21", ALUOutM); end
    // Store: WriteDataM is forwarded B before the immediate mux
    ForwardAE = 2'b00; ForwardBE = 2'b01; ResultW = 32'h55; RD1E = 32'h100; RD2E = 32'h99;
    SignImmE = 32'd4; ALUSrcE = 1; RegWriteE = 0; MemWriteE = 1;
    step();
    nVec++; if (ALUOutM !== 32'h104)   begin nMiss++; $display("FAIL t2_st_addr got %h want 104", ALUOutM); end
    nVec++; if (WriteDataM !== 32'h55) begin nMiss++; $display("FAIL t2_st_data got %h want 55", WriteDataM); end
    nVec++; if ({MemWriteM, RegWriteM} !== 2'b10)
      begin nMiss++; $display("FAIL t2_st_ctrl got %b want 10", {MemWriteM, RegWriteM}); end
  endtask

  task automatic test_alu_ops();
    aluVecT v [13];
    v = '{
      '{4'b0000, 32'h0000FF0F, 32'h00F0F0F0, 5'd0, 32'h0000F000},
      '{4'b0001, 32'h0000FF0F, 32'h00F0F0F0, 5'd0, 32'h00F0FFFF},
      '{4'b0011, 32'h0000FF0F, 32'h00F0F0F0, 5'd0, 32'h00F00FFF},
      '{4'b0100, 32'h0000FF0F, 32'h00F0F0F0, 5'd0, 32'hFF0F0000},
      '{4'b0010, 32'h00000005, 32'hFFFFFFFE, 5'd0, 32'h00000003},
      '{4'b0110, 32'h00000000, 32'h00000001, 5'd0, 32'hFFFFFFFF},
      '{4'b0101, 32'h12345678, 32'h00000003, 5'd4, 32'h00000030},
      '{4'b1000, 32'h12345678, 32'h80000000, 5'd4, 32'h08000000},
      '{4'b1001, 32'h12345678, 32'h80000000, 5'd4, 32'hF8000000},
      '{4'b0111, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000001},
      '{4'b0111, 32'h00000001, 32'hFFFFFFFF, 5'd0, 32'h00000000},
      '{4'b1111, 32'h00000001, 32'h00000001, 5'd0, 32'h00000000},
      '{4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 32'h00000000}
    };
    clear_inputs();
    RegWriteE = 1;
    for (int i = 0; i < 13; i++) begin
      ALUControlE = v[i].ctl; RD1E = v[i].a; RD2E = v[i].b; SaE = v[i].sa;
      step();
      nVec++;
      if (ALUOutM !== v[i].exp)
        begin nMiss++; $display("FAIL alu_op[%0d] ctl=%b got %h want %h", i, v[i].ctl, ALUOutM, v[i].exp); end
    end
  endtask

  task automatic test_mul();
    int cycles;
    clear_inputs();
    ALUControlE = 4'b1010; RD1E = 32'hFFFF_FFFF; RD2E = 32'd3;
    RegWriteE = 1; RegDstE = 1; RdE = 5'd5;
    #1;
    cycles = 0;
    while (StallE === 1'b1 && cycles < 100) begin
      if (cycles == 10) begin RD1E = '0; RD2E = '0; end
      step();
      cycles++;
      nVec++; if (RegWriteM !== 1'b0)
        begin nMiss++; $display("FAIL t3_bubble cycle %0d got %b want 0", cycles, RegWriteM); end
    end
    nVec++; if (cycles != 33) begin nMiss++; $display("FAIL t3_stall_len got %0d want 33", cycles); end
    step();
    nVec++; if (ALUOutM !== 32'hFFFF_FFFD) begin nMiss++; $display("FAIL t3_product got %h want fffffffd", ALUOutM); end
    nVec++; if (RegWriteM !== 1'b1) begin nMiss++; $display("FAIL t3_regwrite got %b want 1", RegWriteM); end
    nVec++; if (WriteRegM !== 5'd5) begin nMiss++; $display("FAIL t3_wreg got %0d want 5", WriteRegM); end
    clear_inputs();
  endtask

  task automatic test_jal();
    clear_inputs();
    ALUControlE = 4'b0010; RD1E = 32'h1234; JumpLinkE = 1; PCPlus4E = 32'h40;
    RegDstE = 1; RdE = 5'd3; RegWriteE = 1;
    step();
    nVec++; if (WriteRegM !== 5'd31)  begin nMiss++; $display("FAIL t4_wreg got %0d want 31", WriteRegM); end
    nVec++; if (ALUOutM !== 32'h40)   begin nMiss++; $display("FAIL t4_aluout got %h want 40", ALUOutM); end
  endtask

  task automatic test_reset_mid_mul();
    int cycles;
    clear_inputs();
    ALUControlE = 4'b1010; RD1E = 32'd9; RD2E = 32'd9; RegDstE = 1; RdE = 5'd7; RegWriteE = 1;
    step();
    repeat (10) step();
    RST_N = 1'b0;
    #1;
    nVec++; if (ALUOutM !== 32'd0)  begin nMiss++; $display("FAIL t5_aluout got %h want 0", ALUOutM); end
    nVec++; if (WriteRegM !== 5'd0) begin nMiss++; $display("FAIL t5_wreg got %0d want 0", WriteRegM); end
    nVec++; if (StallE !== 1'b0)    begin nMiss++; $display("FAIL t5_stall got %b want 0", StallE); end
    clear_inputs();
    @(negedge CLK);
    RST_N = 1'b1;
    ALUControlE = 4'b1010; RD1E = 32'd6; RD2E = 32'd7; RtE = 5'd4; RegWriteE = 1;
    #1;
    wait_stall_low(cycles);
    nVec++; if (cycles != 33) begin nMiss++; $display("FAIL t5_stall_len got %0d want 33", cycles); end
    step();
    nVec++; if (ALUOutM !== 32'd42) begin nMiss++; $display("FAIL t5_product got %0d want 42", ALUOutM); end
    nVec++; if (WriteRegM !== 5'd4) begin nMiss++; $display("FAIL t5_wreg2 got %0d want 4", WriteRegM); end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    int cycles;
    clear_inputs();
    ALUControlE = 4'b1010; RD1E = 32'd3; RD2E = 32'd4; RtE = 5'd2; RegWriteE = 1;
    #1;
    wait_stall_low(cycles);
    step();
    nVec++; if (ALUOutM !== 32'd12) begin nMiss++; $display("FAIL b2b_first got %0d want 12", ALUOutM); end
    RD1E = 32'd5; RD2E = 32'd5; RtE = 5'd3;
    #1;
    nVec++; if (StallE !== 1'b1) begin nMiss++; $display("FAIL b2b_restart got %b want 1", StallE); end
    wait_stall_low(cycles);
    nVec++; if (cycles != 33) begin nMiss++; $display("FAIL b2b_stall_len got %0d want 33", cycles); end
    step();
    nVec++; if (ALUOutM !== 32'd25) begin nMiss++; $display("FAIL b2b_second got %0d want 25", ALUOutM); end
    nVec++; if (WriteRegM !== 5'd3) begin nMiss++; $display("FAIL b2b_wreg got %0d want 3", WriteRegM); end
    clear_inputs();
    ALUControlE = 4'b0010; RD1E = 32'd1; ALUSrcE = 1; SignImmE = 32'd2; RegWriteE = 1;
    #1;
    nVec++; if (StallE !== 1'b0) begin nMiss++; $display("FAIL b2b_add_stall got %b want 0", StallE); end
    step();
    nVec++; if ({ALUOutM, RegWriteM} !== {32'd3, 1'b1})
      begin nMiss++; $display("FAIL b2b_add got %h/%b want 3/1", ALUOutM, RegWriteM); end
  endtask

  task automatic test_overflow();
    logic expRw, expOv;
`ifdef EX_OVERFLOW_TRAP_EN
    expRw = 1'b0; expOv = 1'b1;
`else
    expRw = 1'b1; expOv = 1'b0;
`endif
    clear_inputs();
    ALUControlE = 4'b0010; RD1E = 32'h7FFF_FFFF; RD2E = 32'd1; RegWriteE = 1;
    step();
    nVec++; if (OverflowM !== expOv) begin nMiss++; $display("FAIL t6_add_ovf got %b want %b", OverflowM, expOv); end
    nVec++; if (RegWriteM !== expRw) begin nMiss++; $display("FAIL t6_add_rw got %b want %b", RegWriteM, expRw); end
`ifndef EX_OVERFLOW_TRAP_EN
    nVec++; if (ALUOutM !== 32'h8000_0000) begin nMiss++; $display("FAIL t6_add_wrap got %h want 80000000", ALUOutM); end
`endif
    ALUControlE = 4'b0110; RD1E = 32'h8000_0000; RD2E = 32'd1;
    step();
    nVec++; if (OverflowM !== expOv) begin nMiss++; $display("FAIL t6_sub_ovf got %b want %b", OverflowM, expOv); end
    nVec++; if (RegWriteM !== expRw) begin nMiss++; $display("FAIL t6_sub_rw got %b want %b", RegWriteM, expRw); end
    ALUControlE = 4'b0010; RD1E = 32'h7FFF_FFFE; RD2E = 32'd1;
    step();
    nVec++; if ({OverflowM, RegWriteM} !== 2'b01)
      begin nMiss++; $display("FAIL t6_no_ovf got %b want 01", {OverflowM, RegWriteM}); end
  endtask

  initial begin
    RST_N = 1'b0;
    clear_inputs();
    test_reset();
    test_add_imm();
    test_forwarding();
    test_alu_ops();
    test_mul();
    test_jal();
    test_reset_mid_mul();
    test_back_to_back();
    test_overflow();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
